// File: rtl/i2c_slave_mem.sv
// I2C target fronting a MEM_DEPTH x 8 register memory; first byte is {word_addr[6:0], rw}.
// Define I2C_SLV_BACKDOOR_EN to add a combinational backdoor read port (bd_addr/bd_data).
module i2c_slave_mem #(
  parameter int MEM_DEPTH   = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       wr_strobe,
  output logic [6:0] last_addr
`ifdef I2C_SLV_BACKDOOR_EN
  ,
  input  logic [6:0] bd_addr,
  output logic [7:0] bd_data
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [6:0] ADDR_MASK = 7'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    WR_DATA,
    ACK_DATA,
    RD_DATA,
    MST_ACK,
    WAIT_STOP
  } state_t;

  // Bus handshake: there is no valid/ready pair here; the master owns scl, we only
  // sample sda on synchronized scl rises and change our sda drive on synchronized falls.
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_h_q, scl_h_d;
  logic                   sda_h_q, sda_h_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic [6:0]             addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic                   ack_ph_q, ack_ph_d;
  logic [6:0]             rd_q, rd_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_q, wr_d;

  logic [7:0]             mem_q [MEM_DEPTH];
  logic                   mem_we;
  logic [7:0]             mem_wdata;
  logic [7:0]             mem_rd;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_ev, stop_ev;

  // Gating with rst releases the line combinationally the moment reset asserts.
  assign sda = (sda_oe_q && rst) ? 1'b0 : 1'bz;

  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_strobe = wr_q;
  assign last_addr = addr_q;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_h_q;
  assign scl_fall = ~scl_s & scl_h_q;
  assign start_ev = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_ev  = scl_s & scl_h_q & ~sda_h_q & sda_s;

  assign mem_rd = mem_q[addr_q[AW-1:0]];

`ifdef I2C_SLV_BACKDOOR_EN
  assign bd_data = mem_q[bd_addr[AW-1:0]];
`endif

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_h_d    = scl_s;
    sda_h_d    = sda_s;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    ack_ph_d  = ack_ph_q;
    rd_d      = rd_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_d      = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = {shift_q, sda_s};

    if (stop_ev && (state_q != IDLE)) begin
      // Only a STOP after a fully acknowledged transaction counts as done.
      done_d   = (state_q == WAIT_STOP);
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_ev) begin
      state_d   = ADDR;
      busy_d    = 1'b1;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              addr_d   = shift_q & ADDR_MASK;
              rw_d     = sda_s;
              ack_ph_d = 1'b0;
              state_d  = ACK_ADDR;
            end
          end
        end
        ACK_ADDR: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              bit_cnt_d = 4'd0;
              if (rw_q) begin
                rd_d     = mem_rd[6:0];
                sda_oe_d = ~mem_rd[7];
                state_d  = RD_DATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              mem_we   = 1'b1;
              wr_d     = 1'b1;
              ack_ph_d = 1'b0;
              state_d  = ACK_DATA;
            end
          end
        end
        ACK_DATA: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WAIT_STOP;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = MST_ACK;
            end else begin
              sda_oe_d = ~rd_q[6];
              rd_d     = {rd_q[5:0], 1'b0};
            end
          end
        end
        MST_ACK: begin
          // ACK or NACK both end the single-byte read.
          if (scl_rise) begin
            state_d = WAIT_STOP;
          end
        end
        WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      addr_q     <= 7'd0;
      rw_q       <= 1'b0;
      ack_ph_q   <= 1'b0;
      rd_q       <= 7'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_h_q    <= scl_h_d;
      sda_h_q    <= sda_h_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      ack_ph_q   <= ack_ph_d;
      rd_q       <= rd_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_q       <= wr_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q[AW-1:0]] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: bit-banged master on an open-drain sda with pull-up.
module tb_i2c_slave_mem;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  wire        sda_w;
  logic       busy;
  logic       done;
  logic       wr_strobe;
  logic [6:0] last_addr;
`ifdef I2C_SLV_BACKDOOR_EN
  logic [6:0] bd_addr;
  logic [7:0] bd_data;
`endif

  int n_pass   = 0;
  int n_total  = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  pullup (sda_w);
  assign sda_w = sda_m ? 1'bz : 1'b0;

  i2c_slave_mem dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl_m),
    .sda       (sda_w),
    .busy      (busy),
    .done      (done),
    .wr_strobe (wr_strobe),
`ifdef I2C_SLV_BACKDOOR_EN
    .bd_addr   (bd_addr),
    .bd_data   (bd_data),
`endif
    .last_addr (last_addr)
  );

  // clock / reset
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
    qwait();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    b = sda_w; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d,
                          output logic ack_a, output logic ack_d);
    i2c_start();
    send_byte({a, 1'b0}, ack_a);
    send_byte(d, ack_d);
    i2c_stop();
  endtask

  task automatic do_read(input logic [6:0] a, output logic ack_a, output logic [7:0] v);
    i2c_start();
    send_byte({a, 1'b1}, ack_a);
    read_byte(v);
    send_bit(1'b1);
    i2c_stop();
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %0b exp 0", done); else n_pass++;
    n_total++; if (wr_strobe !== 1'b0) $display("FAIL reset_wr_strobe got %0b exp 0", wr_strobe); else n_pass++;
    n_total++; if (last_addr !== 7'h00) $display("FAIL reset_last_addr got %h exp 00", last_addr); else n_pass++;
    n_total++; if (sda_w !== 1'b1) $display("FAIL reset_sda got %0b exp 1", sda_w); else n_pass++;
    rst = 1'b1;
    qwait();
  endtask

  task automatic test_write();
    int w0, d0;
    logic ack_a, ack_d;
    w0 = wr_cnt; d0 = done_cnt;
    i2c_start();
    send_byte(8'h24, ack_a);
    n_total++; if (busy !== 1'b1) $display("FAIL wr_busy_mid got %0b exp 1", busy); else n_pass++;
    send_byte(8'hA5, ack_d);
    i2c_stop();
    n_total++; if (ack_a !== 1'b0) $display("FAIL wr_ack_addr got %0b exp 0", ack_a); else n_pass++;
    n_total++; if (ack_d !== 1'b0) $display("FAIL wr_ack_data got %0b exp 0", ack_d); else n_pass++;
    n_total++; if (wr_cnt - w0 != 1) $display("FAIL wr_strobe_cnt got %0d exp 1", wr_cnt - w0); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL wr_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
    n_total++; if (last_addr !== 7'h12) $display("FAIL wr_last_addr got %h exp 12", last_addr); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL wr_busy_end got %0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_read();
    int d0;
    logic ack_a;
    logic [7:0] v;
    d0 = done_cnt;
    do_read(7'h12, ack_a, v);
    n_total++; if (ack_a !== 1'b0) $display("FAIL rd_ack_addr got %0b exp 0", ack_a); else n_pass++;
    n_total++; if (v !== 8'hA5) $display("FAIL rd_data got %h exp a5", v); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL rd_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rd_busy_end got %0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_abort();
    int w0, d0;
    logic ack_a, ack_d;
    logic [7:0] v;
    do_write(7'h30, 8'h5A, ack_a, ack_d);
    w0 = wr_cnt; d0 = done_cnt;
    i2c_start();
    send_byte(8'h60, ack_a);
    n_total++; if (ack_a !== 1'b0) $display("FAIL ab_ack_addr got %0b exp 0", ack_a); else n_pass++;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    n_total++; if (wr_cnt - w0 != 0) $display("FAIL ab_wr_cnt got %0d exp 0", wr_cnt - w0); else n_pass++;
    n_total++; if (done_cnt - d0 != 0) $display("FAIL ab_done_cnt got %0d exp 0", done_cnt - d0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL ab_busy got %0b exp 0", busy); else n_pass++;
    n_total++; if (sda_w !== 1'b1) $display("FAIL ab_sda got %0b exp 1", sda_w); else n_pass++;
    do_read(7'h30, ack_a, v);
    n_total++; if (v !== 8'h5A) $display("FAIL ab_mem_kept got %h exp 5a", v); else n_pass++;
  endtask

  task automatic test_repeated_start();
    int w0, d0;
    logic ack_a, ack_r;
    logic [7:0] v;
    w0 = wr_cnt; d0 = done_cnt;
    i2c_start();
    send_byte(8'h0A, ack_a);
    i2c_start();
    n_total++; if (busy !== 1'b1) $display("FAIL rs_busy got %0b exp 1", busy); else n_pass++;
    send_byte(8'h25, ack_r);
    read_byte(v);
    send_bit(1'b1);
    i2c_stop();
    n_total++; if (ack_a !== 1'b0) $display("FAIL rs_ack_wr got %0b exp 0", ack_a); else n_pass++;
    n_total++; if (ack_r !== 1'b0) $display("FAIL rs_ack_rd got %0b exp 0", ack_r); else n_pass++;
    n_total++; if (v !== 8'hA5) $display("FAIL rs_data got %h exp a5", v); else n_pass++;
    n_total++; if (wr_cnt - w0 != 0) $display("FAIL rs_wr_cnt got %0d exp 0", wr_cnt - w0); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL rs_done_cnt got %0d exp 1", done_cnt - d0); else n_pass++;
    n_total++; if (last_addr !== 7'h12) $display("FAIL rs_last_addr got %h exp 12", last_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic ack_a, b7;
    logic [7:0] v;
    i2c_start();
    send_byte(8'h25, ack_a);
    read_bit(b7);
    n_total++; if (b7 !== 1'b1) $display("FAIL rm_bit7 got %0b exp 1", b7); else n_pass++;
    n_total++; if (sda_w !== 1'b0) $display("FAIL rm_bit6_driven got %0b exp 0", sda_w); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (sda_w !== 1'b1) $display("FAIL rm_sda_released got %0b exp 1", sda_w); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rm_busy got %0b exp 0", busy); else n_pass++;
    qwait();
    rst = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    qwait(); qwait();
    do_read(7'h12, ack_a, v);
    n_total++; if (v !== 8'hA5) $display("FAIL rm_data_after got %h exp a5", v); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ack_a, ack_d;
    logic [7:0] v;
    do_write(7'h7F, 8'h3C, ack_a, ack_d);
    n_total++; if (ack_d !== 1'b0) $display("FAIL bb_ack_data got %0b exp 0", ack_d); else n_pass++;
    do_read(7'h7F, ack_a, v);
    n_total++; if (v !== 8'h3C) $display("FAIL bb_data_7f got %h exp 3c", v); else n_pass++;
    n_total++; if (last_addr !== 7'h7F) $display("FAIL bb_last_addr got %h exp 7f", last_addr); else n_pass++;
    do_read(7'h12, ack_a, v);
    n_total++; if (v !== 8'hA5) $display("FAIL bb_data_12 got %h exp a5", v); else n_pass++;
`ifdef I2C_SLV_BACKDOOR_EN
    bd_addr = 7'h7F;
    #1;
    n_total++; if (bd_data !== 8'h3C) $display("FAIL bd_data_7f got %h exp 3c", bd_data); else n_pass++;
    bd_addr = 7'h12;
    #1;
    n_total++; if (bd_data !== 8'hA5) $display("FAIL bd_data_12 got %h exp a5", bd_data); else n_pass++;
`endif
  endtask

  initial begin
`ifdef I2C_SLV_BACKDOOR_EN
    bd_addr = 7'h00;
`endif
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_repeated_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
